// File: rtl/frame_color_scanner_if.sv
// Bus between the frame colour scanner and its surroundings: scan
// request/handshake from the system controller, the camera busy flag,
// the frame buffer processing read port and the published results.
interface frame_color_scanner_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          start;
    logic          cam_busy;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_data;
    logic          busy;
    logic          done;
    logic [1:0]    color;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_g;
    logic [AW-1:0] cnt_b;
    logic [7:0]    xmin;
    logic [7:0]    xmax;
    logic [6:0]    ymin;
    logic [6:0]    ymax;

    // scanner side
    modport slave (
        input  start, cam_busy, proc_data,
        output proc_addr, busy, done, color, cnt_r, cnt_g, cnt_b,
               xmin, xmax, ymin, ymax
    );

    // controller / frame buffer side
    modport master (
        output start, cam_busy, proc_data,
        input  proc_addr, busy, done, color, cnt_r, cnt_g, cnt_b,
               xmin, xmax, ymin, ymax
    );
endinterface

// File: rtl/frame_color_scanner.sv
// Frame colour scanner: walks every pixel of the RGB332 frame buffer once,
// classifies each pixel as red/green/blue/none, counts each class and
// reports the dominant colour. A scan is only started while the camera is
// not writing the buffer. Optional bounding-box tracking of all classified
// pixels is enabled with the macro SCAN_BBOX_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// WAIT_CAM | scan accepted, waiting for capture path to release buffer
// PRIME    | clear accumulators, address 0
// SCAN     | one address per cycle; sample data one cycle behind
// DECIDE   | pick dominant colour, publish counts (and bbox)
// DONE     | one-cycle done pulse, back to IDLE
module frame_color_scanner #(
    parameter int AW      = 15,
    parameter int DW      = 8,
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int MIN_PIX = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_color_scanner_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_CAM, PRIME, SCAN, DECIDE, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic          valid_q;
    logic          end_q;
    logic [AW-1:0] acc_r_q, acc_g_q, acc_b_q;
    logic [AW-1:0] cnt_r_q, cnt_g_q, cnt_b_q;
    logic [1:0]    color_q;
    logic          busy_q;
    logic          done_q;

    logic [DW-1:0] pix_d;
    logic [1:0]    cls_d;
    logic [1:0]    win_color_d;
    logic [AW-1:0] win_cnt_d;

    // Classify the pixel returned by the buffer; first matching class wins.
    always_comb begin
        pix_d = bus.proc_data;
        cls_d = 2'd0;
        if (pix_d[7:5] >= 3'd5 && pix_d[4:2] <= 3'd2 && pix_d[1:0] <= 2'd1)
            cls_d = 2'd1;
        else if (pix_d[4:2] >= 3'd5 && pix_d[7:5] <= 3'd2 && pix_d[1:0] <= 2'd1)
            cls_d = 2'd2;
        else if (pix_d[1:0] == 2'd3 && pix_d[7:5] <= 3'd2 && pix_d[4:2] <= 3'd2)
            cls_d = 2'd3;
    end

    // Dominant colour; strict '>' keeps the earlier colour on a tie.
    always_comb begin
        win_color_d = 2'd1;
        win_cnt_d   = acc_r_q;
        if (acc_g_q > win_cnt_d) begin
            win_color_d = 2'd2;
            win_cnt_d   = acc_g_q;
        end
        if (acc_b_q > win_cnt_d) begin
            win_color_d = 2'd3;
            win_cnt_d   = acc_b_q;
        end
        if (win_cnt_d < AW'(MIN_PIX))
            win_color_d = 2'd0;
    end

    // Sequencer, address generator, per-class accumulators and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            acc_r_q <= '0;
            acc_g_q <= '0;
            acc_b_q <= '0;
            cnt_r_q <= '0;
            cnt_g_q <= '0;
            cnt_b_q <= '0;
            color_q <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= WAIT_CAM;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_CAM: begin
                    if (!bus.cam_busy)
                        state_q <= PRIME;
                end
                PRIME: begin
                    acc_r_q <= '0;
                    acc_g_q <= '0;
                    acc_b_q <= '0;
                    addr_q  <= '0;
                    valid_q <= 1'b0;
                    end_q   <= 1'b0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    // data for the previous address is on proc_data now
                    valid_q <= 1'b1;
                    if (valid_q) begin
                        case (cls_d)
                            2'd1:    acc_r_q <= acc_r_q + AW'(1);
                            2'd2:    acc_g_q <= acc_g_q + AW'(1);
                            2'd3:    acc_b_q <= acc_b_q + AW'(1);
                            default: ;
                        endcase
                    end
                    // address parks on LAST for one extra cycle to catch its data
                    if (addr_q != LAST)
                        addr_q <= addr_q + AW'(1);
                    else
                        end_q <= 1'b1;
                    if (end_q)
                        state_q <= DECIDE;
                end
                DECIDE: begin
                    cnt_r_q <= acc_r_q;
                    cnt_g_q <= acc_g_q;
                    cnt_b_q <= acc_b_q;
                    color_q <= win_color_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.proc_addr = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.color     = color_q;
    assign bus.cnt_r     = cnt_r_q;
    assign bus.cnt_g     = cnt_g_q;
    assign bus.cnt_b     = cnt_b_q;

`ifdef SCAN_BBOX_EN
    logic [7:0] x_q, px_q, bx0_q, bx1_q, xmin_q, xmax_q;
    logic [6:0] y_q, py_q, by0_q, by1_q, ymin_q, ymax_q;
    logic       found_q;

    // Pixel coordinates follow the address; px/py lag one cycle to line up
    // with proc_data. Running box is published in DECIDE (zero if empty).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            bx0_q   <= '0;
            bx1_q   <= '0;
            by0_q   <= '0;
            by1_q   <= '0;
            found_q <= 1'b0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
        end else begin
            case (state_q)
                PRIME: begin
                    x_q     <= '0;
                    y_q     <= '0;
                    found_q <= 1'b0;
                end
                SCAN: begin
                    px_q <= x_q;
                    py_q <= y_q;
                    if (addr_q != LAST) begin
                        if (x_q == 8'(IMG_W - 1)) begin
                            x_q <= '0;
                            y_q <= y_q + 7'd1;
                        end else begin
                            x_q <= x_q + 8'd1;
                        end
                    end
                    if (valid_q && cls_d != 2'd0) begin
                        found_q <= 1'b1;
                        if (!found_q || px_q < bx0_q) bx0_q <= px_q;
                        if (!found_q || px_q > bx1_q) bx1_q <= px_q;
                        if (!found_q || py_q < by0_q) by0_q <= py_q;
                        if (!found_q || py_q > by1_q) by1_q <= py_q;
                    end
                end
                DECIDE: begin
                    xmin_q <= found_q ? bx0_q : 8'd0;
                    xmax_q <= found_q ? bx1_q : 8'd0;
                    ymin_q <= found_q ? by0_q : 7'd0;
                    ymax_q <= found_q ? by1_q : 7'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.xmin = xmin_q;
    assign bus.xmax = xmax_q;
    assign bus.ymin = ymin_q;
    assign bus.ymax = ymax_q;
`else
    assign bus.xmin = 8'd0;
    assign bus.xmax = 8'd0;
    assign bus.ymin = 7'd0;
    assign bus.ymax = 7'd0;
`endif
endmodule

// File: doc/frame_color_scanner.md
Name: frame_color_scanner

Overview:
Sequences the processing read port of the dual-port frame buffer. On request, walks every pixel of the 160x120 RGB332 image once and classifies each pixel as red, green, blue or none. Reports per-colour pixel counts and the dominant colour to the system controller. Start is gated so a scan never begins while the camera capture path is writing a frame.

Parameters:
AW, 15, address width of the frame buffer processing port
DW, 8, pixel width (RGB332: R=[7:5], G=[4:2], B=[1:0])
IMG_W, 160, image width in pixels
IMG_H, 120, image height in pixels
MIN_PIX, 64, minimum winning count for a colour to be reported

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  scan request, single-cycle pulse or level
cam_busy  in  1  high while capture is writing the buffer
proc_addr  out  AW  address to buffer processing read port
proc_data  in  DW  pixel returned for proc_addr
busy  out  1  high from scan accept until done
done  out  1  one-cycle pulse when results are valid
color  out  2  0=none, 1=red, 2=green, 3=blue
cnt_r  out  AW  red pixel count
cnt_g  out  AW  green pixel count
cnt_b  out  AW  blue pixel count
xmin, xmax  out  8  bounding box x bounds (see Optional Feature)
ymin, ymax  out  7  bounding box y bounds (see Optional Feature)

Behaviour:
- Reset (async, any state): FSM to IDLE; proc_addr=0, busy=0, done=0, color=0, cnt_*=0, bbox outputs=0.
- FSM states: IDLE, WAIT_CAM, PRIME, SCAN, DECIDE, DONE.
  - IDLE: start=1 -> WAIT_CAM. start is sampled only in IDLE; start while busy is ignored (not queued).
  - WAIT_CAM: hold while cam_busy=1; when cam_busy=0 -> PRIME. busy=1 from entry to WAIT_CAM onward.
  - PRIME: clears internal accumulators; proc_addr=0; -> SCAN.
  - SCAN: each cycle proc_addr advances by 1, up to IMG_W*IMG_H-1. proc_data is treated as valid exactly one cycle after proc_addr is driven. The pixel x/y coordinates are delayed one cycle alongside it. Last sample is taken the cycle after address 19199 -> DECIDE.
  - DECIDE: compute color; publish cnt_* and bbox to outputs -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- cam_busy rising during PRIME/SCAN is ignored; a scan never aborts except by rst.
- Latency: from cam_busy=0 in WAIT_CAM to the done pulse is exactly IMG_W*IMG_H+3 cycles (19203).
- Pixel classes, evaluated in order; the first match wins:
  - red: R>=5, G<=2, B<=1
  - green: G>=5, R<=2, B<=1
  - blue: B==3, R<=2, G<=2
  - otherwise none
- Counters are AW bits wide. Maximum count is 19200 < 2^15, so counters never overflow.
- Dominant colour: the largest of cnt_r, cnt_g, cnt_b. Ties resolve red > green > blue. If the winning count < MIN_PIX, color=0.
- Outputs cnt_*, color and bbox change only in DECIDE and hold until the next DECIDE.
- proc_addr holds its last value outside SCAN.

Optional Feature:
Macro SCAN_BBOX_EN.
- Defined: track the bounding box of all classified (non-none) pixels. Running min/max is updated on every valid sample and published in DECIDE. If no pixel is classified, output xmin=0, xmax=0, ymin=0, ymax=0.
- Undefined: no bbox logic is synthesized; xmin/xmax/ymin/ymax are tied to 0.

Test Plan:
- All pixels 8'hE0, start with cam_busy=0 -> done 19203 cycles after PRIME entry; cnt_r=19200, cnt_g=0, cnt_b=0, color=1.
- Image all 8'h00 except a 10x10 block of 8'h1C at x=20..29, y=30..39 -> cnt_g=100, color=2. With SCAN_BBOX_EN: xmin=20, xmax=29, ymin=30, ymax=39.
- 63 blue pixels (8'h03), rest 8'h00 -> cnt_b=63, color=0 (below MIN_PIX).
- 100 red and 100 blue pixels -> color=1 (tie-break); then pulse start while busy=1 -> no second scan, exactly one done pulse.
- Hold cam_busy=1 for 500 cycles after start -> proc_addr stays 0, busy=1; scan begins the cycle after cam_busy falls.
- Assert rst at pixel 5000 mid-scan -> all outputs 0 immediately, FSM in IDLE; next start gives correct full-frame counts.
